multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/ctrl_pkg.sv | 53 +++++
 rtl/ctrl_wait_timer.sv | 35 +++
 rtl/multicycle_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multicycle controller.
//   state_t          - controller FSM states
//   OP_*             - 4-bit opcode encodings
//   DEF_TIMEOUT_CYC  - default memory wait limit before fault
//   decode_op()      - next state selected in DECODE for a legal 4-bit opcode
package ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_MEM_RD,
      S_MEM_WR,
      S_EXEC,
      S_JUMP,
      S_HALT,
      S_FAULT
   } state_t;

   localparam logic [3:0] OP_STORE = 4'b0000;
   localparam logic [3:0] OP_ADD   = 4'b0001;
   localparam logic [3:0] OP_SUB   = 4'b0010;
   localparam logic [3:0] OP_AND   = 4'b0011;
   localparam logic [3:0] OP_OR    = 4'b0100;
   localparam logic [3:0] OP_XOR   = 4'b0101;
   localparam logic [3:0] OP_NAND  = 4'b0110;
   localparam logic [3:0] OP_NOR   = 4'b0111;
   localparam logic [3:0] OP_NOT   = 4'b1000;
   localparam logic [3:0] OP_XNOR  = 4'b1001;
   localparam logic [3:0] OP_LOADI = 4'b1010;
   localparam logic [3:0] OP_JZ    = 4'b1011;
   localparam logic [3:0] OP_HALT  = 4'b1110;
   localparam logic [3:0] OP_JMP   = 4'b1111;

   localparam int DEF_TIMEOUT_CYC = 15;

   function automatic state_t decode_op(input logic [3:0] op);
      state_t nxt;
      if (op == OP_STORE)
         nxt = S_MEM_WR;
      else if (op >= OP_ADD && op <= OP_XNOR)
         nxt = S_MEM_RD;
      else if (op == OP_LOADI)
         nxt = S_EXEC;
      else if (op == OP_JZ || op == OP_JMP)
         nxt = S_JUMP;
      else if (op == OP_HALT)
         nxt = S_HALT;
      else
         nxt = S_FAULT;
      return nxt;
   endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// ctrl_wait_timer: counts memory wait cycles and flags a timeout.
//   clk, rst_n - clock, async active-low reset
//   clear      - zero the count (takes priority over enable)
//   enable     - count this cycle (memory not ready)
//   expired    - this enabled cycle brings the count to TIMEOUT_CYC
module ctrl_wait_timer
#(
   parameter int TIMEOUT_CYC = 15
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (enable)
         cnt <= cnt + CW'(1);
   end

   // Flag the cycle whose increment reaches the limit, so the FSM can
   // leave for FAULT on the very next edge.
   assign expired = enable && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FSM sequencing a multicycle accumulator datapath.
//   clk, rst_n        - clock, async active-low reset
//   opcode            - instruction opcode, stable after FETCH
//   mem_ready         - data memory completes current access
//   ac_zero           - accumulator is zero
//   mem_rd, mem_wr, ld_ac, ac_src, pc_src, jmp_uncond - datapath controls
//   ir_ld, pc_inc, instr_done - IR load, PC increment, retire pulse
//   halted, fault     - sticky status until reset
//   instr_count       - retired instruction count (wraps)
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int OPCODE_W    = 4,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int CNT_W       = 16
)
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   input  logic                ac_zero,
   output logic                mem_rd,
   output logic                mem_wr,
   output logic                ld_ac,
   output logic                ac_src,
   output logic                pc_src,
   output logic                jmp_uncond,
   output logic                ir_ld,
   output logic                pc_inc,
   output logic                instr_done,
   output logic                halted,
   output logic                fault,
   output logic [CNT_W-1:0]    instr_count
);

   state_t state;
   logic   jmp_q;       // JUMP is unconditional (captured in DECODE)
   logic   halt_first;  // first cycle in HALT, retires the HALT itself
   logic   tmr_clear;
   logic   tmr_en;
   logic   tmr_expired;
   logic   op_legal;

   // Any set bit above the 4-bit opcode field makes the instruction illegal.
   assign op_legal  = ((opcode >> 4) == '0);
   assign tmr_clear = (state == S_DECODE);
   assign tmr_en    = (state == S_MEM_RD || state == S_MEM_WR) && !mem_ready;

   ctrl_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (tmr_clear),
      .enable  (tmr_en),
      .expired (tmr_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_FETCH;
         jmp_q       <= 1'b0;
         halt_first  <= 1'b0;
         instr_count <= '0;
      end else begin
         halt_first <= 1'b0;
         if (instr_done)
            instr_count <= instr_count + CNT_W'(1);
         case (state)
            S_FETCH:  state <= S_DECODE;
            S_DECODE: begin
               jmp_q <= (opcode[3:0] == OP_JMP);
               if (!op_legal)
                  state <= S_FAULT;
               else begin
                  state <= decode_op(opcode[3:0]);
                  if (decode_op(opcode[3:0]) == S_HALT)
                     halt_first <= 1'b1;
               end
            end
            // Ready wins over a simultaneous timeout.
            S_MEM_RD, S_MEM_WR: begin
               if (mem_ready)
                  state <= S_FETCH;
               else if (tmr_expired)
                  state <= S_FAULT;
            end
            S_EXEC, S_JUMP: state <= S_FETCH;
            default:        state <= state;  // HALT / FAULT hold until reset
         endcase
      end
   end

   always_comb begin
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      ld_ac      = 1'b0;
      ac_src     = 1'b0;
      pc_src     = 1'b0;
      jmp_uncond = 1'b0;
      ir_ld      = 1'b0;
      pc_inc     = 1'b0;
      instr_done = 1'b0;
      halted     = 1'b0;
      fault      = 1'b0;
      case (state)
         // State is FETCH throughout reset; keep ir_ld quiet until release.
         S_FETCH: ir_ld = rst_n;
         S_MEM_RD: begin
            mem_rd     = 1'b1;
            ld_ac      = mem_ready;
            pc_inc     = mem_ready;
            instr_done = mem_ready;
         end
         S_MEM_WR: begin
            mem_wr     = 1'b1;
            pc_inc     = mem_ready;
            instr_done = mem_ready;
         end
         S_EXEC: begin
            ld_ac      = 1'b1;
            ac_src     = 1'b1;
            pc_inc     = 1'b1;
            instr_done = 1'b1;
         end
         S_JUMP: begin
            pc_src     = jmp_q | ac_zero;
            jmp_uncond = jmp_q;
            pc_inc     = !jmp_q && !ac_zero;
            instr_done = 1'b1;
         end
         S_HALT: begin
            halted     = 1'b1;
            instr_done = halt_first;
         end
         S_FAULT: fault = 1'b1;
         default: ;
      endcase
   end

endmodule
